// File: rtl/clz_pkg.sv
// Shared definitions for the CLZ/CLO unit: widths, state encoding and the
// state enum used by the control FSM.
package clz_pkg;

  localparam int OP_W   = 32;
  localparam int HALF_W = 16;
  localparam int RES_W  = 6;
  localparam int CNT_W  = 5;

  // Core count value meaning "all sixteen bits were zero"
  localparam logic [CNT_W-1:0] CNT_ALL0 = 5'd16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HI   = 2'd1;
  localparam logic [1:0] ST_LO   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HI   = ST_HI,
    LO   = ST_LO,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/clz16_core.sv
// Purely combinational 16-bit leading-zero counter. Output is 0..16, where
// 16 means the input was all zeros.
module clz16_core
  import clz_pkg::*;
(
  input  logic [HALF_W-1:0] din,
  output logic [CNT_W-1:0]  cnt
);

  // Scan from LSB to MSB so the most significant set bit is the last to win
  always_comb begin
    cnt = CNT_ALL0;
    for (int i = 0; i < HALF_W; i++) begin
      if (din[i]) cnt = CNT_W'(HALF_W - 1 - i);
    end
  end

endmodule

// File: rtl/clz_unit.sv
// Multi-cycle count-leading-zeros / count-leading-ones unit.
// The operand is counted one 16-bit half at a time through a single shared
// clz16_core. CLO is handled by inverting the operand when it is latched.
// Optional macro CLZ_EARLY_EXIT_EN: skip the LO state when the upper half
// already contains a set bit, shortening latency from +3 to +2.
module clz_unit
  import clz_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            op_clo,
  input  logic [OP_W-1:0] rs,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [OP_W-1:0] rd
);

  state_t            state;
  state_t            state_nx;
  logic [OP_W-1:0]   opnd;
  logic [RES_W-1:0]  acc;
  logic              upper_nz;
  logic [HALF_W-1:0] half;
  logic [CNT_W-1:0]  cnt;
  logic              done_q;
  logic [OP_W-1:0]   rd_q;

  // The single core looks at the lower half only while in LO
  assign half = (state == LO) ? opnd[HALF_W-1:0] : opnd[OP_W-1:HALF_W];

  clz16_core u_core (
    .din (half),
    .cnt (cnt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; cancel overrides everything, including a start in IDLE
  always_comb begin
    state_nx = state;
    if (cancel) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_nx = HI;
`ifdef CLZ_EARLY_EXIT_EN
        HI:   state_nx = (cnt != CNT_ALL0) ? DONE : LO;
`else
        HI:   state_nx = LO;
`endif
        LO:   state_nx = DONE;
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Operand capture and accumulation of the two half counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd     <= '0;
      acc      <= '0;
      upper_nz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) opnd <= op_clo ? ~rs : rs;
        end
        HI: begin
          acc      <= {1'b0, cnt};
          upper_nz <= (cnt != CNT_ALL0);
        end
        LO: begin
          if (!upper_nz) acc <= acc + {1'b0, cnt};
        end
        default: ;
      endcase
    end
  end

  // Registered result and one-cycle done pulse, both suppressed by cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == DONE && !cancel) begin
        done_q <= 1'b1;
        rd_q   <= {{(OP_W-RES_W){1'b0}}, acc};
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign rd   = rd_q;

endmodule

// File: tb/tb_clz_unit.sv
// Self-checking bench for clz_unit: table of directed vectors plus hand
// sequences for busy-ignore, cancel and asynchronous reset.
module tb_clz_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op_clo;
  logic [31:0] rs;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] rd;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_rd;

  typedef struct {
    logic        clo;
    logic [31:0] val;
    logic [31:0] exp_rd;
    int          lat_early;
    string       name;
  } vec_t;

  vec_t vecs[12];

  clz_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_clo (op_clo),
    .rs     (rs),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .rd     (rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge: drives a one-cycle start request
  task automatic applyStimulus(input logic clo, input logic [31:0] val);
    start  = 1'b1;
    op_clo = clo;
    rs     = val;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    op_clo = 1'b0;
    rs     = 32'h0;
  endtask

  // Runs one operation from a negedge and checks result, latency and pulse count
  task automatic runVector(input logic clo, input logic [31:0] val, input logic [31:0] exp_rd,
                           input int exp_lat, input string name);
    int seen_k;
    int pulses;
    logic busy_k1;
    seen_k  = 0;
    pulses  = 0;
    busy_k1 = 1'b0;
    applyStimulus(clo, val);
    busy_k1 = busy;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        pulses++;
        if (seen_k == 0) seen_k = k;
      end
    end
    checkOutput({name, "_busy"}, 32'(busy_k1), 32'd1);
    checkOutput({name, "_rd"}, rd, exp_rd);
    checkOutput({name, "_lat"}, 32'(seen_k), 32'(exp_lat));
    checkOutput({name, "_pulses"}, 32'(pulses), 32'd1);
    last_rd = exp_rd;
  endtask

  function automatic int latOf(input int lat_early);
`ifdef CLZ_EARLY_EXIT_EN
    return lat_early;
`else
    return 3 + 0 * lat_early;
`endif
  endfunction

  initial begin
    int pulses;

    vecs[0]  = '{1'b0, 32'h8000_0000, 32'd0,  2, "clz_msb"};
    vecs[1]  = '{1'b0, 32'h0000_8000, 32'd16, 3, "clz_b15"};
    vecs[2]  = '{1'b0, 32'h0000_0001, 32'd31, 3, "clz_lsb"};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'd32, 3, "clz_zero"};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'd32, 3, "clo_ones"};
    vecs[5]  = '{1'b1, 32'hFFFF_0000, 32'd16, 3, "clo_hi"};
    vecs[6]  = '{1'b0, 32'h0001_0000, 32'd15, 2, "clz_b16"};
    vecs[7]  = '{1'b1, 32'hF000_0000, 32'd4,  2, "clo_f"};
    vecs[8]  = '{1'b0, 32'h0000_FFFF, 32'd16, 3, "clz_lof"};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFE, 32'd31, 3, "clo_31"};
    vecs[10] = '{1'b0, 32'h1234_5678, 32'd3,  2, "clz_mix"};
    vecs[11] = '{1'b1, 32'hFFFF_8000, 32'd17, 3, "clo_17"};

    rst_n   = 1'b0;
    start   = 1'b0;
    op_clo  = 1'b0;
    rs      = 32'h0;
    cancel  = 1'b0;
    last_rd = 32'h0;

    // Reset values while reset is held
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_rd", rd, 32'd0);

    // Release and start on the very first edge after release
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      runVector(vecs[i].clo, vecs[i].val, vecs[i].exp_rd, latOf(vecs[i].lat_early), vecs[i].name);
    end

    // Start while busy with a different operand is ignored
    pulses = 0;
    start  = 1'b1;
    op_clo = 1'b0;
    rs     = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    rs = 32'h8000_0000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 2) begin
        start = 1'b0;
        rs    = 32'h0;
      end
      if (done) pulses++;
    end
    checkOutput("busy_ign_rd", rd, 32'd31);
    checkOutput("busy_ign_pulses", 32'(pulses), 32'd1);
    last_rd = 32'd31;

    // Cancel while in HI
    pulses = 0;
    start  = 1'b1;
    rs     = 32'h0000_FFFF;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b1;
    checkOutput("cancel_inhi", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("cancel_pulses", 32'(pulses), 32'd0);
    checkOutput("cancel_rd", rd, last_rd);

    // Cancel together with start in IDLE drops the start
    pulses = 0;
    start  = 1'b1;
    cancel = 1'b1;
    rs     = 32'h0;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    checkOutput("cstart_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("cstart_pulses", 32'(pulses), 32'd0);
    checkOutput("cstart_rd", rd, last_rd);

    // Asynchronous reset while in LO, between clock edges
    pulses = 0;
    start  = 1'b1;
    rs     = 32'h0000_0001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_rd", rd, 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("arst_pulses", 32'(pulses), 32'd0);
    runVector(1'b0, 32'h0000_0100, 32'd23, 3, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
